// File: rtl/mul_ctrl.sv
// mul_ctrl: multicycle sequencer around the combinational 32x32 unsigned
// multiplier array for MULT/MULTU. Operands are reduced to magnitudes,
// held stable for MUL_CYCLES cycles, then the sign-corrected product is
// registered and announced with a one-cycle ready / HI-LO write strobe.

// Combinational 32x32 unsigned array; constrained as a multicycle path.
module mul (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] p
);
   assign p = {32'b0, a} * {32'b0, b};
endmodule

module mul_ctrl #(
   parameter int MUL_CYCLES = 2  // legal range 1..8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        signed_op,
   input  logic        cancel,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        stall,
   output logic        busy,
   output logic        ready,
   output logic        hilo_we,
   output logic [63:0] result
);
   // MUL_CYCLES-1 is at most 7, so three bits cover the hold counter.
   localparam int CW = 3;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    ua_q, ua_d;
   logic [31:0]    ub_q, ub_d;
   logic           neg_q, neg_d;
   logic [63:0]    result_q, result_d;
   logic [63:0]    prod;

   // The array sees only the captured magnitudes, stable for all of CALC.
   mul u_mul (
      .a (ua_q),
      .b (ub_q),
      .p (prod)
   );

   // State register and datapath flops; reset clears everything.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ua_q     <= '0;
         ub_q     <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ua_q     <= ua_d;
         ub_q     <= ub_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   // Next-state and datapath updates; cancel overrides everything and never
   // touches the result register.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ua_d     = ua_q;
      ub_d     = ub_q;
      neg_d    = neg_q;
      result_d = result_q;
      if (cancel) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  // -0x80000000 wraps to 0x80000000, which is the right
                  // unsigned magnitude for the array.
                  ua_d    = (signed_op && op_a[31]) ? (~op_a + 32'd1) : op_a;
                  ub_d    = (signed_op && op_b[31]) ? (~op_b + 32'd1) : op_b;
                  neg_d   = signed_op & (op_a[31] ^ op_b[31]);
                  cnt_d   = CW'(MUL_CYCLES - 1);
                  state_d = CALC;
               end
            end
            CALC: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
               end else begin
                  result_d = neg_q ? (~prod + 64'd1) : prod;
                  state_d  = DONE;
               end
            end
            DONE: state_d = IDLE;  // start seen here belongs to this op
            default: state_d = IDLE;
         endcase
      end
   end

   // Pipeline handshake outputs; stall is held low while in reset so a
   // start held across reset cannot freeze the pipeline.
   always_comb begin
      stall   = resetn & ~cancel &
                (((state_q == IDLE) & start) | (state_q == CALC));
      busy    = (state_q == CALC) | (state_q == DONE);
      ready   = (state_q == DONE) & ~cancel;
      hilo_we = ready;
      result  = result_q;
   end

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: directed vectors, randomized operands against a
// plain-arithmetic product model, back-to-back, cancel and reset abort.
module tb_mul_ctrl;
   localparam int MC = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0, signed_op = 1'b0, cancel = 1'b0;
   logic [31:0] op_a = '0, op_b = '0;
   logic        stall, busy, ready, hilo_we;
   logic [63:0] result;

   int nvec = 0;
   int nerr = 0;
   logic [63:0] last_res = '0;

   // Expected per-cycle masks: stall in cycles 0..MC, ready in MC+1.
   localparam logic [15:0] EXP_ST = 16'((1 << (MC + 1)) - 1);
   localparam logic [15:0] EXP_RD = 16'(1 << (MC + 1));

   always #5 clk = ~clk;

   mul_ctrl #(.MUL_CYCLES(MC)) dut (
      .clk(clk), .resetn(resetn), .start(start), .signed_op(signed_op),
      .cancel(cancel), .op_a(op_a), .op_b(op_b), .stall(stall),
      .busy(busy), .ready(ready), .hilo_we(hilo_we), .result(result)
   );

   // Reference product from plain integer arithmetic.
   function automatic logic [63:0] ref_prod(input logic [31:0] a, b, input logic s);
      longint sa, sb;
      logic [63:0] ua, ub;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      ua = {32'b0, a};
      ub = {32'b0, b};
      return ua * ub;
   endfunction

   // Drive one request and record what the DUT shows in each cycle. Ends in
   // cycle MC+1 so a following call starts in the IDLE cycle right after.
   task automatic do_op(input logic [31:0] a, b, input logic s,
                        output logic [15:0] st, rd, hw, output logic [63:0] res);
      st = '0; rd = '0; hw = '0; res = 'x;
      @(negedge clk);
      start = 1'b1; signed_op = s; op_a = a; op_b = b; cancel = 1'b0;
      for (int c = 0; c <= MC + 1; c++) begin
         #1;
         st[c] = stall; rd[c] = ready; hw[c] = hilo_we;
         if (ready) res = result;
         if (c < MC + 1) @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start = 1'b0; cancel = 1'b0;
      end
   endtask

   task automatic test_reset;
      start = 1'b1; op_a = 32'd5; op_b = 32'd7;
      #12;
      nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL reset_stall: got %b expected 0", stall); end
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", busy); end
      nvec++; if ({ready, hilo_we} !== 2'b00) begin nerr++; $display("FAIL reset_ready: got %b expected 00", {ready, hilo_we}); end
      nvec++; if (result !== 64'd0) begin nerr++; $display("FAIL reset_result: got %h expected 0", result); end
      @(negedge clk); start = 1'b0; resetn = 1'b1;
      idle(1);
   endtask

   // One checked operation; every field compared against the model.
   task automatic test_one(input string nm, input logic [31:0] a, b, input logic s);
      logic [15:0] st, rd, hw;
      logic [63:0] res, exp_r;
      exp_r = ref_prod(a, b, s);
      do_op(a, b, s, st, rd, hw, res);
      nvec++; if (st !== EXP_ST) begin nerr++; $display("FAIL %s_stall: got %b expected %b", nm, st, EXP_ST); end
      nvec++; if (rd !== EXP_RD) begin nerr++; $display("FAIL %s_ready: got %b expected %b", nm, rd, EXP_RD); end
      nvec++; if (hw !== EXP_RD) begin nerr++; $display("FAIL %s_hilo_we: got %b expected %b", nm, hw, EXP_RD); end
      nvec++; if (res !== exp_r) begin nerr++; $display("FAIL %s_result: got %h expected %h", nm, res, exp_r); end
      last_res = exp_r;
   endtask

   task automatic test_directed;
      logic [63:0] e;
      e = ref_prod(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      nvec++; if (e !== 64'hFFFFFFFE00000001) begin nerr++; $display("FAIL model_multu: got %h expected FFFFFFFE00000001", e); end
      test_one("multu_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); idle(1);
      test_one("mult_m3x5", 32'hFFFFFFFD, 32'd5, 1'b1); idle(1);
      test_one("mult_min2", 32'h80000000, 32'h80000000, 1'b1); idle(1);
      test_one("mult_m1m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); idle(1);
      test_one("multu_min2", 32'h80000000, 32'd2, 1'b0); idle(1);
      test_one("mult_min2s", 32'h80000000, 32'd2, 1'b1); idle(1);
   endtask

   task automatic test_random;
      logic [31:0] a, b;
      logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         test_one("rand", a, b, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(1);
   endtask

   task automatic test_back_to_back;
      logic [15:0] st1, rd1, hw1, st2, rd2, hw2;
      logic [63:0] r1, r2;
      logic [31:0] extra;
      do_op(32'd3, 32'd4, 1'b0, st1, rd1, hw1, r1);
      do_op(32'd7, 32'd6, 1'b0, st2, rd2, hw2, r2);
      nvec++; if (rd1 !== EXP_RD || rd2 !== EXP_RD) begin nerr++; $display("FAIL b2b_ready: got %b/%b expected %b", rd1, rd2, EXP_RD); end
      nvec++; if (st2 !== EXP_ST) begin nerr++; $display("FAIL b2b_stall2: got %b expected %b", st2, EXP_ST); end
      nvec++; if (r1 !== 64'hC) begin nerr++; $display("FAIL b2b_res1: got %h expected c", r1); end
      nvec++; if (r2 !== 64'h2A) begin nerr++; $display("FAIL b2b_res2: got %h expected 2a", r2); end
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); start = 1'b0; #1;
         if (ready || busy) extra++;
      end
      nvec++; if (extra !== 0) begin nerr++; $display("FAIL b2b_no_third: got %0d extra cycles expected 0", extra); end
      last_res = 64'h2A;
   endtask

   task automatic test_cancel;
      @(negedge clk); start = 1'b1; signed_op = 1'b0; op_a = 32'd10; op_b = 32'd10;
      @(negedge clk); cancel = 1'b1; #1;
      nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL cancel_calc_stall: got %b expected 0", stall); end
      nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL cancel_calc_ready: got %b expected 0", ready); end
      @(negedge clk); cancel = 1'b0; start = 1'b0; #1;
      nvec++; if ({busy, stall, ready} !== 3'b000) begin nerr++; $display("FAIL cancel_idle: got %b expected 000", {busy, stall, ready}); end
      nvec++; if (result !== last_res) begin nerr++; $display("FAIL cancel_result: got %h expected %h", result, last_res); end
      for (int i = 0; i < MC + 2; i++) begin
         @(negedge clk); #1;
         nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL cancel_late_ready: got %b expected 0", ready); end
      end
      // Cancel landing exactly on DONE suppresses the strobe.
      @(negedge clk); start = 1'b1; op_a = 32'd9; op_b = 32'd9;
      repeat (MC + 1) @(negedge clk);
      cancel = 1'b1; #1;
      nvec++; if ({ready, hilo_we, stall} !== 3'b000) begin nerr++; $display("FAIL cancel_done: got %b expected 000", {ready, hilo_we, stall}); end
      nvec++; if (result !== 64'd81) begin nerr++; $display("FAIL cancel_done_result: got %h expected 51", result); end
      @(negedge clk); cancel = 1'b0; start = 1'b0; #1;
      nvec++; if ({busy, ready} !== 2'b00) begin nerr++; $display("FAIL cancel_done_after: got %b expected 00", {busy, ready}); end
      last_res = 64'd81;
   endtask

   task automatic test_reset_mid;
      @(negedge clk); start = 1'b1; signed_op = 1'b0; op_a = 32'd11; op_b = 32'd13;
      @(negedge clk); #1;
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rmid_busy_pre: got %b expected 1", busy); end
      resetn = 1'b0; #1;
      nvec++; if ({stall, busy, ready} !== 3'b000) begin nerr++; $display("FAIL rmid_ctrl: got %b expected 000", {stall, busy, ready}); end
      nvec++; if (result !== 64'd0) begin nerr++; $display("FAIL rmid_result: got %h expected 0", result); end
      @(negedge clk); start = 1'b0;
      @(negedge clk); resetn = 1'b1;
      test_one("post_reset", 32'd2, 32'd3, 1'b0);
      idle(2);
   endtask

   initial begin
      test_reset;
      test_directed;
      test_random;
      test_back_to_back;
      test_cancel;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- Multicycle sequencer wrapping the team's combinational 32x32 unsigned multiplier array (`mul`) for MULT/MULTU execution in the EX stage.
- Captures operands and converts signed operands to magnitudes, then holds the array inputs stable for MUL_CYCLES cycles so the array can be constrained as a multicycle path.
- Registers the 64-bit product with sign correction.
- Stalls the pipeline until the result is ready and pulses a HI/LO write strobe.

Parameters:
- MUL_CYCLES, 2, number of cycles the array inputs are held before the product is captured; legal range 1..8.

Ports:
- clk  input  1  system clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- start  input  1  EX-stage multiply request; held high by the pipeline while stall is high
- signed_op  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start in IDLE
- cancel  input  1  pipeline flush (exception/eret); aborts any operation
- op_a  input  32  multiplicand, sampled in IDLE
- op_b  input  32  multiplier, sampled in IDLE
- stall  output  1  pipeline hold request
- busy  output  1  high in CALC or DONE
- ready  output  1  one-cycle result-valid pulse
- hilo_we  output  1  HI/LO write enable, equal to ready
- result  output  64  product; {HI, LO} = result[63:32], result[31:0]

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, counter=0, operand regs=0, neg flag=0, result=0. All control outputs are 0 while reset is asserted.
- State encoding: IDLE, CALC, DONE.
- IDLE:
  - If start=1 and cancel=0:
    - latch ua = (signed_op & op_a[31]) ? -op_a : op_a; ub likewise from op_b.
    - latch neg = signed_op & (op_a[31] ^ op_b[31]).
    - counter <= MUL_CYCLES-1; go to CALC.
  - Otherwise stay in IDLE.
- CALC:
  - The array inputs are driven only from ua/ub, which are stable throughout CALC.
  - If counter != 0: counter <= counter-1.
  - If counter == 0: result <= neg ? -P : P, where P = array output (64-bit, two's complement negate mod 2^64); go to DONE.
- DONE: ready=1, hilo_we=1, then go to IDLE unconditionally. start in DONE belongs to the completing instruction and is never treated as a new request.
- stall = (state==IDLE & start & ~cancel) | (state==CALC). stall is 0 in DONE, so the pipeline advances in the same cycle ready pulses.
- busy = (state==CALC) | (state==DONE).
- Latency:
  - start sampled in cycle 0; stall high in cycles 0..MUL_CYCLES; ready in cycle MUL_CYCLES+1.
  - Total stall is MUL_CYCLES+1 cycles.
- Back-to-back multiplies: the next instruction's start is first seen in IDLE, the cycle after DONE. Throughput is one multiply per MUL_CYCLES+2 cycles.
- cancel:
  - Highest priority in every state; next state is IDLE.
  - ready and hilo_we are forced to 0 in the cancel cycle, including when the state is DONE.
  - stall is 0 in the cancel cycle.
  - result retains its previous value.
- Width rules:
  - The magnitude of 0x80000000 is 0x80000000 as unsigned, which is correct for the unsigned array.
  - A signed product fits in 64 bits, so negation never overflows incorrectly.
- result holds its last captured value until the next capture; it is never cleared except by reset.
- Asynchronous reset mid-operation aborts immediately with no ready pulse. The first start after reset release behaves as from IDLE.
- MUL_CYCLES=1: CALC lasts exactly one cycle.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, MUL_CYCLES=2 -> stall high in cycles 0-2; ready/hilo_we pulse in cycle 3 only; result=0xFFFFFFFE00000001.
- MULT -3 (0xFFFFFFFD) x 5 -> result=0xFFFFFFFFFFFFFFF1. MULT 0x80000000 x 0x80000000 -> result=0x4000000000000000. MULT -1 x -1 -> result=0x0000000000000001.
- MULTU 0x80000000 x 2 -> result=0x0000000100000000. The same operands with signed_op=1 -> result=0xFFFFFFFF00000000.
- Back-to-back MULTU 3x4 then 7x6 with start held per stall protocol -> two ready pulses 4 cycles apart; results 0xC then 0x2A; no third pulse.
- cancel asserted during CALC (cycle 1) of 10x10 -> next cycle IDLE; stall=0; no ready; result unchanged. cancel coincident with DONE -> ready=0, hilo_we=0.
- resetn pulled low during CALC -> state IDLE, stall=0, result=0 immediately. After release, MULTU 2x3 -> result=6 after MUL_CYCLES+1 cycles.
